pipe_stage_reg: RTL and testbench

- Parametrised, handshaked successor to the fixed IF/ID latch; serves as the generic inter-stage register for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a PC and a payload word with valid/ready flow control.
- A 2-entry skid buffer keeps one transfer per cycle under back-pressure, and ready stays registered.
- Synchronous flush kills in-flight entries; empty slots present a NOP so downstream decode stays benign.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_entry_reg.sv | 46 ++++
 rtl/pipe_stage_reg.sv | 155 +++++++++++++++
 tb/tb_pipe_stage_reg.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the generic handshaked inter-stage register.
// Holds the state encoding, the default NOP payload and the bubble counter width.
package pipe_pkg;

  // Encoded as {skid.valid, main.valid}; 2'b10 cannot occur.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } pipe_state_e;

  localparam logic [31:0] PIPE_NOP     = 32'h0000_0000;
  localparam int          BUBBLE_CNT_W = 16;

endpackage

// File: rtl/pipe_entry_reg.sv
// One {valid, pc, data} slot of the stage register.
// Clear wins over load; an empty slot always holds pc=0 and the NOP payload.
module pipe_entry_reg
  import pipe_pkg::*;
#(
  parameter int                PC_W    = 32,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(PIPE_NOP)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] data_q;

  // Slot storage: clear empties the slot, load captures a new entry.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      data_q  <= NOP_VAL;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      data_q  <= NOP_VAL;
    end else if (load_i) begin
      valid_q <= 1'b1;
      pc_q    <= pc_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready inter-stage register with a 2-entry skid buffer.
// Optional macro PIPE_STAGE_REG_BUBBLE_CNT_EN adds a saturating bubble_cnt port.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int                PC_W    = 32,
  parameter int                DATA_W  = 32,
  parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(PIPE_NOP)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_REG_BUBBLE_CNT_EN
  ,
  output logic [BUBBLE_CNT_W-1:0] bubble_cnt
`endif
);

  logic              main_v;
  logic [PC_W-1:0]   main_pc;
  logic [DATA_W-1:0] main_data;
  logic              skid_v;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_data;

  logic              main_load;
  logic              main_clear;
  logic [PC_W-1:0]   main_pc_d;
  logic [DATA_W-1:0] main_data_d;
  logic              skid_load;
  logic              skid_clear;
  logic              skid_v_d;

  logic              in_ready_q;
  logic              in_fire;
  logic              out_fire;
  pipe_state_e       state;

  assign state    = pipe_state_e'({skid_v, main_v});
  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = main_v & out_ready;

  // Next-slot control; flush outranks every transfer and drops the input.
  always_comb begin
    main_load   = 1'b0;
    main_clear  = 1'b0;
    main_pc_d   = in_pc;
    main_data_d = in_data;
    skid_load   = 1'b0;
    skid_clear  = 1'b0;
    skid_v_d    = skid_v;
    if (flush) begin
      main_clear = 1'b1;
      skid_clear = 1'b1;
      skid_v_d   = 1'b0;
    end else begin
      unique case (state)
        ST_EMPTY: begin
          if (in_fire) main_load = 1'b1;
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            skid_v_d  = 1'b1;
          end else if (out_fire) begin
            main_clear = 1'b1;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            main_load   = 1'b1;
            main_pc_d   = skid_pc;
            main_data_d = skid_data;
            skid_clear  = 1'b1;
            skid_v_d    = 1'b0;
          end
        end
        default: begin
          main_clear = 1'b1;
          skid_clear = 1'b1;
          skid_v_d   = 1'b0;
        end
      endcase
    end
  end

  pipe_entry_reg #(
    .PC_W    (PC_W),
    .DATA_W  (DATA_W),
    .NOP_VAL (NOP_VAL)
  ) u_main (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (main_load),
    .clear_i (main_clear),
    .pc_i    (main_pc_d),
    .data_i  (main_data_d),
    .valid_o (main_v),
    .pc_o    (main_pc),
    .data_o  (main_data)
  );

  pipe_entry_reg #(
    .PC_W    (PC_W),
    .DATA_W  (DATA_W),
    .NOP_VAL (NOP_VAL)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (rst),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .pc_i    (in_pc),
    .data_i  (in_data),
    .valid_o (skid_v),
    .pc_o    (skid_pc),
    .data_o  (skid_data)
  );

  // Registered ready: accept whenever the skid slot will be free next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) in_ready_q <= 1'b0;
    else      in_ready_q <= ~skid_v_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v;
  assign out_pc    = main_pc;
  assign out_data  = main_data;

`ifdef PIPE_STAGE_REG_BUBBLE_CNT_EN
  logic [BUBBLE_CNT_W-1:0] bubble_q;

  // Saturating count of cycles where downstream waited on an empty stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bubble_q <= '0;
    end else if (!main_v && out_ready && (bubble_q != '1)) begin
      bubble_q <= bubble_q + BUBBLE_CNT_W'(1);
    end
  end

  assign bubble_cnt = bubble_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg.
// Uses a non-zero NOP payload so empty-slot data is distinguishable from zero.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_data;
`ifdef PIPE_STAGE_REG_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int checks;
  int errors;
  logic [65:0] obs;
  logic [65:0] exp;

  pipe_stage_reg #(
    .PC_W    (32),
    .DATA_W  (32),
    .NOP_VAL (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_data  (out_data)
`ifdef PIPE_STAGE_REG_BUBBLE_CNT_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc,
                       input logic [31:0] d);
    in_valid = v;
    in_pc    = pc;
    in_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h40, 32'hDEAD_BEEF);
    tick();
    tick();
    obs = {out_valid, out_pc, out_data, in_ready};
    exp = {1'b0, 32'h0, NOP, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL reset_hold got %h want %h", obs, exp);
    end
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_rdy got %b want 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_rise got %b want 1", in_ready);
    end
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'hA0 + 32'(i));
      tick();
      obs = {out_valid, out_pc, out_data, in_ready};
      exp = {1'b1, 32'(4 * i), 32'hA0 + 32'(i), 1'b1};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL stream_%0d got %h want %h", i, obs, exp);
      end
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    obs = {out_valid, out_pc, out_data, in_ready};
    exp = {1'b0, 32'h0, NOP, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL stream_drain got %h want %h", obs, exp);
    end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    drive(1'b1, 32'h0, 32'hB0);
    tick();
    obs = {out_valid, out_pc, out_data, in_ready};
    exp = {1'b1, 32'h0, 32'hB0, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_first got %h want %h", obs, exp);
    end
    drive(1'b1, 32'h4, 32'hB1);
    tick();
    obs = {out_valid, out_pc, out_data, in_ready};
    exp = {1'b1, 32'h0, 32'hB0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_full got %h want %h", obs, exp);
    end
    drive(1'b1, 32'h8, 32'hB2);
    for (int i = 0; i < 2; i++) begin
      tick();
      obs = {out_valid, out_pc, out_data, in_ready};
      exp = {1'b1, 32'h0, 32'hB0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL bp_hold_%0d got %h want %h", i, obs, exp);
      end
    end
    out_ready = 1'b1;
    tick();
    obs = {out_valid, out_pc, out_data, in_ready};
    exp = {1'b1, 32'h4, 32'hB1, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_skid_out got %h want %h", obs, exp);
    end
    tick();
    obs = {out_valid, out_pc, out_data, in_ready};
    exp = {1'b1, 32'h8, 32'hB2, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_third got %h want %h", obs, exp);
    end
    drive(1'b0, 32'h0, 32'h0);
    tick();
    obs = {out_valid, out_pc, out_data, in_ready};
    exp = {1'b0, 32'h0, NOP, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL bp_empty got %h want %h", obs, exp);
    end
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0;
    drive(1'b1, 32'h0, 32'hC0);
    tick();
    drive(1'b1, 32'h4, 32'hC4);
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_prefill got %b want 0", in_ready);
    end
    flush = 1'b1;
    drive(1'b1, 32'h8, 32'hC8);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    obs = {out_valid, out_pc, out_data, in_ready};
    exp = {1'b0, 32'h0, NOP, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL flush_after got %h want %h", obs, exp);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      obs = {out_valid, out_pc, out_data, in_ready};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL flush_no_pc8_%0d got %h want %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(1'b1, 32'h10, 32'hE0);
    tick();
    drive(1'b1, 32'h14, 32'hE4);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    obs = {out_valid, out_pc, out_data, in_ready};
    exp = {1'b1, 32'h10, 32'hE0, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rstmid_full got %h want %h", obs, exp);
    end
    #2;
    rst = 1'b0;
    #1;
    obs = {out_valid, out_pc, out_data, in_ready};
    exp = {1'b0, 32'h0, NOP, 1'b0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rstmid_async got %h want %h", obs, exp);
    end
    #1;
    rst = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_rdy got %b want 1", in_ready);
    end
    out_ready = 1'b1;
    drive(1'b1, 32'h100, 32'hD1);
    tick();
    drive(1'b0, 32'h0, 32'h0);
    obs = {out_valid, out_pc, out_data, in_ready};
    exp = {1'b1, 32'h100, 32'hD1, 1'b1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL rstmid_pass got %h want %h", obs, exp);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_drain got %b want 0", out_valid);
    end
  endtask

`ifdef PIPE_STAGE_REG_BUBBLE_CNT_EN
  task automatic test_bubble_cnt();
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    checks++;
    if (bubble_cnt !== 16'h0) begin
      errors++;
      $display("FAIL bubble_rst got %h want 0000", bubble_cnt);
    end
    rst = 1'b1;
    repeat (5) tick();
    checks++;
    if (bubble_cnt !== 16'd5) begin
      errors++;
      $display("FAIL bubble_5 got %h want 0005", bubble_cnt);
    end
    repeat (65529) tick();
    checks++;
    if (bubble_cnt !== 16'hFFFE) begin
      errors++;
      $display("FAIL bubble_fffe got %h want fffe", bubble_cnt);
    end
    repeat (3) tick();
    checks++;
    if (bubble_cnt !== 16'hFFFF) begin
      errors++;
      $display("FAIL bubble_sat got %h want ffff", bubble_cnt);
    end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush_full();
    test_reset_mid();
`ifdef PIPE_STAGE_REG_BUBBLE_CNT_EN
    test_bubble_cnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
